matmul_engine: RTL
==================

MATMUL_ENGINE -- requirements
Module: matmul_engine

Interface
REQ-001 Parameter N, default 2, matrix dimension (square NxN); legal range 1..8.
REQ-002 Parameter DATA_W, default 32, element width in bits; signed two's complement.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand set is present on mat_a/mat_b/mode.
REQ-006 in_ready  output  1  engine can accept an operand set.
REQ-007 mode  input  1  0 = C = A*B; 1 = C = Cprev + A*B (accumulate into held result).
REQ-008 mat_a  input  N*N*DATA_W  matrix A, element [r][c] at bits (r*N+c)*DATA_W +: DATA_W.
REQ-009 mat_b  input  N*N*DATA_W  matrix B, same packing as mat_a.
REQ-010 out_valid  output  1  mat_c holds a completed result.
REQ-011 out_ready  input  1  consumer accepts mat_c.
REQ-012 mat_c  output  N*N*DATA_W  result matrix, same packing as mat_a.
REQ-013 cycle_count  output  32  number of clocks spent in COMPUTE since reset.

Function
REQ-014 FSM states IDLE, COMPUTE, DONE shall be implemented; no other states reachable.
REQ-015 in_ready shall be 1 only in IDLE; out_valid shall be 1 only in DONE.
REQ-016 IDLE: on in_valid & in_ready, mat_a, mat_b and mode shall be latched and the FSM shall move to COMPUTE with indices i=j=k=0.
REQ-017 Inputs mat_a/mat_b/mode shall be ignored outside the accept edge; changes during COMPUTE/DONE have no effect.
REQ-018 COMPUTE: exactly one multiply-accumulate per clock, acc += A[i][k]*B[k][j], k innermost, then j, then i.
REQ-019 At k=0 acc shall start from 0 (mode 0) or from held C[i][j] (mode 1).
REQ-020 When k=N-1, the completed sum shall be written to C[i][j] on that edge.
REQ-021 COMPUTE shall last exactly N*N*N clocks; out_valid shall rise on the edge N*N*N clocks after the accept edge (8 for N=2).
REQ-022 Products and sums shall be truncated to DATA_W bits (modulo 2^DATA_W wrap); no saturation, no overflow flag.
REQ-023 mat_c shall update only when an element is written; it shall hold its value in IDLE and DONE and across operations.
REQ-024 DONE: on out_valid & out_ready the FSM shall return to IDLE; in_ready shall be 1 the following cycle (no same-cycle accept in DONE).
REQ-025 DONE with out_ready=0 shall hold out_valid=1 and mat_c stable indefinitely.
REQ-026 cycle_count shall increment by 1 on every clock spent in COMPUTE and wrap from 0xFFFFFFFF to 0.
REQ-027 mode 1 issued as first operation after reset shall accumulate onto zero (equals mode 0 result).

Reset
REQ-028 While rst=1 on a rising edge: FSM to IDLE, in_ready=1, out_valid=0, mat_c=0, cycle_count=0, indices and acc = 0.
REQ-029 rst asserted during COMPUTE or DONE shall abort the operation; no partial result is retained and no out_valid pulse follows.
REQ-030 rst shall take priority over in_valid and out_ready on the same edge.

Verification
REQ-031 N=2, mode 0, A=[1,2;3,4], B=[5,6;7,8] -> mat_c=[19,22;43,50], out_valid exactly 8 clocks after accept, cycle_count=8.
REQ-032 Repeat with mode 1, same operands -> mat_c=[38,44;86,100], cycle_count=16.
REQ-033 A=[-1,0;0,1], B=[3,0;0,0x80000000], then A=[2,0;0,2]*B=[0x80000000,0;0,1] -> first [0xFFFFFFFD,0;0,0x80000000], second [0,0;0,2] (wrap).
REQ-034 out_ready held 0 for 5 clocks in DONE -> out_valid and mat_c stable, in_ready=0, cycle_count unchanged; out_ready=1 -> IDLE next clock.
REQ-035 rst pulsed at COMPUTE cycle 4 -> next clock in_ready=1, out_valid=0, mat_c=0, cycle_count=0; new operation then produces correct result.
REQ-036 N=4, A=identity, B=elements 0..15 -> mat_c equals B, out_valid 64 clocks after accept.

Source files
------------

// File: rtl/matmul_engine.sv
// Sequential NxN matrix multiplier with optional accumulate into the held result.
// One multiply-accumulate per clock, k innermost, then j, then i.
// Element [r][c] of every packed matrix port sits at bits (r*N+c)*DATA_W +: DATA_W.
module matmul_engine #(
  parameter int N      = 2,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     mode,
  input  logic [N*N*DATA_W-1:0]    mat_a,
  input  logic [N*N*DATA_W-1:0]    mat_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N*N*DATA_W-1:0]    mat_c,
  output logic [31:0]              cycle_count
);

  localparam int              IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] a_q [N][N];
  logic [DATA_W-1:0] b_q [N][N];
  logic [DATA_W-1:0] c_q [N][N];
  logic              mode_q;
  logic [IDX_W-1:0]  i_q, j_q, k_q;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] base;
  logic [DATA_W-1:0] sum;
  logic              accept;
  logic              computing;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_ready && in_valid;
  assign computing = (state == COMPUTE);

  // Current MAC: the first term of each dot product seeds from zero or the held C.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    base = acc;
    if (k_q == '0) base = mode_q ? c_q[i_q][j_q] : '0;
    // Both the product and the sum are evaluated at DATA_W bits, so they wrap modulo 2^DATA_W.
    sum = base + a_q[i_q][k_q] * b_q[k_q][j_q];
  end

  // Operand capture on the accept edge; operands are don't-care until then.
  always_ff @(posedge clk) begin
    // NOTE: operand arrays are plain storage with no reset; only state that is observable after reset is cleared.
    if (accept) begin
      mode_q <= mode;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_q[r][c] <= mat_a[(r*N+c)*DATA_W +: DATA_W];
          b_q[r][c] <= mat_b[(r*N+c)*DATA_W +: DATA_W];
        end
      end
    end
  end

  // FSM, loop indices, accumulator, result storage and compute-cycle counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    if (rst) begin
      state       <= IDLE;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      acc         <= '0;
      cycle_count <= '0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) c_q[r][c] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state <= COMPUTE;
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            acc   <= '0;
          end
        end
        COMPUTE: begin
          cycle_count <= cycle_count + 32'd1;
          if (k_q == LAST) begin
            c_q[i_q][j_q] <= sum;
            acc           <= '0;
            k_q           <= '0;
            if (j_q == LAST) begin
              j_q <= '0;
              if (i_q == LAST) begin
                i_q   <= '0;
                state <= DONE;
              end else begin
                i_q <= i_q + IDX_W'(1);
              end
            end else begin
              j_q <= j_q + IDX_W'(1);
            end
          end else begin
            acc <= sum;
            k_q <= k_q + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Flatten the held result onto the output port.
  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      assign mat_c[(r*N+c)*DATA_W +: DATA_W] = c_q[r][c];
    end
  end

  // Computing flag kept for readability of the FSM; referenced here to document intent.
  logic unused_ok;
  assign unused_ok = computing;

endmodule
